bus_io_responder: RTL and testbench
===================================

# bus_io_responder

Peripheral-side responder on the CPU's 16-bit bidirectional data bus: the far end of the CPU transceiver. It accepts CPU write cycles into a transmit FIFO toward an external device, and answers CPU read cycles by driving the bus from a receive FIFO or a status word. It handles the select/read-write/acknowledge handshake, tri-state control of the shared bus, and overflow/underflow bookkeeping.

## Interface
- DEPTH, 4: entries per FIFO; power of two, 2..8.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- cs  in  1  CPU chip select; a transaction is pending while high.
- rw  in  1  1 = CPU read (responder drives bus), 0 = CPU write (CPU drives bus).
- addr  in  1  0 = data port, 1 = status/control port.
- bidir  inout  16  shared data bus; high-Z unless this block is driving.
- ack  out  1  one-cycle acknowledge pulse.
- dev_out_data  out  16  transmit FIFO head toward device.
- dev_out_valid  out  1  transmit FIFO not empty.
- dev_out_ready  in  1  device accepts dev_out_data this cycle.
- dev_in_data  in  16  word from device.
- dev_in_valid  in  1  device offers dev_in_data.
- dev_in_ready  out  1  receive FIFO not full.

## Operation
- FSM states: IDLE, ACK, HOLD.
  - IDLE: cs=1 at a rising edge accepts the transaction and moves to ACK.
  - ACK: ack=1 for exactly this cycle. Next state is HOLD if cs=1, else IDLE.
  - HOLD: waits for cs=0, then returns to IDLE. No re-accept while cs stays high, so one access per select assertion.
- Actions taken at the acceptance edge:
  - Write, addr=0: bidir is pushed into the TX FIFO. If TX is full the word is dropped and sticky ovf is set.
  - Write, addr=1: bit0=1 flushes both FIFOs (counts to 0). Bit1=1 clears both sticky flags. Other bits are ignored.
  - Read, addr=0: RX head is popped into the rdata register. If RX is empty, rdata=16'h0000 and sticky unf is set.
  - Read, addr=1: rdata is loaded with the status word, and both sticky flags clear on the same edge.
- Status word layout:
  - [0] rx_not_empty, [1] tx_full, [2] ovf, [3] unf, [7:4] 0.
  - [11:8] rx_count, [15:12] tx_count.
  - Values reflect the state just before the acceptance edge.
- Bus drive: bidir = rdata when (state ∈ {ACK, HOLD}) & cs & rw; otherwise 16'bz. The block never drives during IDLE.
- Device side, both FIFOs, at any edge:
  - TX pops when dev_out_valid & dev_out_ready.
  - RX pushes when dev_in_valid & dev_in_ready.
- Simultaneous push and pop on one FIFO both take effect; the count is unchanged.
- Full/empty decisions use pre-edge flags:
  - A CPU write to a full TX is dropped even if the device pops on the same edge.
  - A CPU read of an empty RX underflows even if the device pushes on the same edge.
- Flush on the same edge as a device push/pop: flush wins, and the count becomes 0.
- Counts wrap-free: pointers are log2(DEPTH) bits with a modulo wrap; counts are log2(DEPTH)+1 bits.

## Timing
- Reset (asynchronous, reset=0):
  - state=IDLE, ack=0, bidir=Z.
  - dev_out_valid=0, dev_out_data=0, dev_in_ready=1.
  - rdata=0, flags=0, pointers and counts=0.
- Reset mid-transaction aborts the transaction immediately; the bus is released asynchronously.
- Acceptance edge to ack: 1 cycle. Read data is valid on bidir from the cycle after acceptance until cs falls; the CPU samples at the edge ending the ACK cycle.
- Minimum back-to-back access: 3 cycles (accept, ACK, cs low in IDLE).
- dev_out_valid and dev_in_ready are registered-state functions; they update the cycle after any push, pop or flush.
- Device-side throughput: one word per cycle per FIFO.

## Structure
- Package io_pkg: FSM state encoding, ADDR_DATA/ADDR_STAT constants, status bit positions, control bit positions (CTL_FLUSH=0, CTL_CLR=1).
- Sub-module sync_fifo (parameters WIDTH, DEPTH), instantiated twice (TX and RX).
  - Ports: push, pop, flush, din, dout (head), full, empty, count.
- The top level holds the FSM, rdata, sticky flags and tri-state driver.

## Test plan
- Reset, then CPU writes 16'hA5A5 and 16'h1234 with dev_out_ready=0 → ack pulses once per write; dev_out_valid=1 and dev_out_data=16'hA5A5. Then raise dev_out_ready → 16'hA5A5 then 16'h1234 are delivered, and valid drops.
- Device pushes 16'hBEEF, then CPU reads addr=0 → ack one cycle after acceptance; bidir=16'hBEEF during ACK/HOLD and Z after cs falls.
- Five writes with DEPTH=4 and the device stalled → the fifth is dropped; status read returns 16'h4006; a second status read shows bit2=0.
- CPU reads an empty RX while the device pushes 16'h0F0F on the same edge → rdata=16'h0000, unf set; a following read returns 16'h0F0F.
- cs held high for 6 cycles on a read → exactly one pop and one ack pulse; the FSM stays in HOLD until cs=0.
- reset asserted during ACK of a read → bidir goes Z and ack=0 at once; all FIFOs are empty after release; status reads 16'h0000.

Source files
------------

// File: rtl/io_pkg.sv
// Package for the CPU bus responder.
// Holds the handshake FSM encoding, the port address decode, the status word
// bit positions and the control word bit positions.
package io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_STAT = 1'b1;

  localparam int STAT_RX_NE     = 0;
  localparam int STAT_TX_FULL   = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_UNF       = 3;
  localparam int STAT_RXCNT_LSB = 8;
  localparam int STAT_TXCNT_LSB = 12;

  localparam int CTL_FLUSH = 0;
  localparam int CTL_CLR   = 1;

endpackage

// File: rtl/bus_io_responder_if.sv
// CPU-side select / direction / address / acknowledge handshake.
// The shared 16-bit data bus stays a plain inout port on the responder.
//   cs   : chip select, transaction pending while high
//   rw   : 1 = CPU read, 0 = CPU write
//   addr : 0 = data port, 1 = status/control port
//   ack  : one-cycle acknowledge from the responder
interface bus_io_responder_if;
  logic cs;
  logic rw;
  logic addr;
  logic ack;

  modport master (output cs, output rw, output addr, input ack);
  modport slave  (input cs, input rw, input addr, output ack);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and flush.
// Ports: clk, reset (async active-low), push, pop, flush (wins over push/pop),
//        din, dout (head, 0 while empty), full, empty, count.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = cnt;
  // Head reads as zero when empty so the device port shows 0 after reset.
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/bus_io_responder.sv
// Peripheral-side responder on the CPU 16-bit bidirectional data bus.
// CPU writes to the data port fill the TX FIFO toward the device; CPU reads
// of the data port pop the RX FIFO; the status port returns flags and counts,
// and writes to it flush FIFOs / clear sticky flags.
// Ports: clk, reset (async active-low), bus (cs/rw/addr/ack handshake),
//        bidir (shared data bus), dev_out_* (TX toward device),
//        dev_in_* (RX from device).
module bus_io_responder
  import io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_io_responder_if.slave     bus,
  inout  wire  [15:0]           bidir,
  output logic [15:0]           dev_out_data,
  output logic                  dev_out_valid,
  input  logic                  dev_out_ready,
  input  logic [15:0]           dev_in_data,
  input  logic                  dev_in_valid,
  output logic                  dev_in_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t          state;
  state_t          state_nxt;
  logic [15:0]     rdata;
  logic [15:0]     status;
  logic            ovf;
  logic            unf;
  logic            bus_oe;

  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]   tx_count, rx_count;
  logic [15:0]     rx_head;

  logic            accept;
  logic            wr_data, wr_ctl, rd_data, rd_stat;
  logic            ctl_flush, ctl_clr;

  assign accept    = (state == ST_IDLE) & bus.cs;
  assign wr_data   = accept & ~bus.rw & (bus.addr == ADDR_DATA);
  assign wr_ctl    = accept & ~bus.rw & (bus.addr == ADDR_STAT);
  assign rd_data   = accept &  bus.rw & (bus.addr == ADDR_DATA);
  assign rd_stat   = accept &  bus.rw & (bus.addr == ADDR_STAT);
  assign ctl_flush = wr_ctl & bidir[CTL_FLUSH];
  assign ctl_clr   = wr_ctl & bidir[CTL_CLR];

  // Full/empty below are registered, so every decision uses pre-edge state.
  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_tx (
    .clk   (clk),
    .reset (reset),
    .push  (wr_data & ~tx_full),
    .pop   (dev_out_ready & ~tx_empty),
    .flush (ctl_flush),
    .din   (bidir),
    .dout  (dev_out_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_rx (
    .clk   (clk),
    .reset (reset),
    .push  (dev_in_valid & ~rx_full),
    .pop   (rd_data & ~rx_empty),
    .flush (ctl_flush),
    .din   (dev_in_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign dev_out_valid = ~tx_empty;
  assign dev_in_ready  = ~rx_full;

  always_comb begin
    status                          = '0;
    status[STAT_RX_NE]              = ~rx_empty;
    status[STAT_TX_FULL]            = tx_full;
    status[STAT_OVF]                = ovf;
    status[STAT_UNF]                = unf;
    status[STAT_RXCNT_LSB +: 4]     = 4'(rx_count);
    status[STAT_TXCNT_LSB +: 4]     = 4'(tx_count);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.cs) state_nxt = ST_ACK;
      ST_ACK:  state_nxt = bus.cs ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (!bus.cs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.ack = (state == ST_ACK);

  // Bus is driven only after acceptance and drops the instant cs or rw falls.
  assign bus_oe = (state != ST_IDLE) & bus.cs & bus.rw;
  assign bidir  = bus_oe ? rdata : 16'bz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (wr_data && tx_full) ovf <= 1'b1;
      if (ctl_clr) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
      if (rd_data) begin
        rdata <= rx_empty ? 16'h0000 : rx_head;
        if (rx_empty) unf <= 1'b1;
      end
      if (rd_stat) begin
        rdata <= status;
        ovf   <= 1'b0;
        unf   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_io_responder.sv
module tb_bus_io_responder;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bus_io_responder_if bus();

  wire  [15:0] bidir;
  logic        cpu_oe = 1'b0;
  logic [15:0] cpu_wdata = 16'h0;
  assign bidir = cpu_oe ? cpu_wdata : 16'bz;

  logic [15:0] dev_out_data;
  logic        dev_out_valid;
  logic        dev_out_ready = 1'b0;
  logic [15:0] dev_in_data = 16'h0;
  logic        dev_in_valid = 1'b0;
  logic        dev_in_ready;

  bus_io_responder #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .bidir         (bidir),
    .dev_out_data  (dev_out_data),
    .dev_out_valid (dev_out_valid),
    .dev_out_ready (dev_out_ready),
    .dev_in_data   (dev_in_data),
    .dev_in_valid  (dev_in_valid),
    .dev_in_ready  (dev_in_ready)
  );

  int errors = 0;
  int checks = 0;
  bit dev_rand = 1'b0;

  // Reference model: the two FIFOs as queues plus sticky flags and read register.
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  logic [15:0] m_rdata = 16'h0;
  logic [15:0] last_bus = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = 16'h0;
    s[0] = (rx_q.size() != 0);
    s[1] = (tx_q.size() == DEPTH);
    s[2] = m_ovf;
    s[3] = m_unf;
    s[11:8]  = 4'(rx_q.size());
    s[15:12] = 4'(tx_q.size());
    return s;
  endfunction

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rdata = 16'h0;
  endtask

  // One clock edge; acc marks the edge at which the CPU access is accepted.
  task automatic tick(input bit acc);
    bit          tx_full, rx_empty, tx_pop, rx_push, flush;
    logic [15:0] st;
    if (dev_rand) begin
      dev_in_valid  = 1'($urandom_range(0, 1));
      dev_in_data   = 16'($urandom);
      dev_out_ready = 1'($urandom_range(0, 1));
      #1;
    end
    chk("dev_out_valid", 32'(dev_out_valid), 32'(tx_q.size() != 0));
    chk("dev_in_ready", 32'(dev_in_ready), 32'(rx_q.size() < DEPTH));
    chk("dev_out_data", 32'(dev_out_data), 32'((tx_q.size() != 0) ? tx_q[0] : 16'h0));
    tx_full  = (tx_q.size() == DEPTH);
    rx_empty = (rx_q.size() == 0);
    tx_pop   = dev_out_ready && (tx_q.size() != 0);
    rx_push  = dev_in_valid && (rx_q.size() < DEPTH);
    st       = m_status();
    flush    = 1'b0;
    if (tx_pop) void'(tx_q.pop_front());
    if (acc) begin
      if (!bus.rw && !bus.addr) begin
        if (tx_full) m_ovf = 1'b1;
        else tx_q.push_back(cpu_wdata);
      end else if (!bus.rw) begin
        flush = cpu_wdata[0];
        if (cpu_wdata[1]) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end
      end else if (!bus.addr) begin
        if (rx_empty) begin
          m_rdata = 16'h0;
          m_unf = 1'b1;
        end else begin
          m_rdata = rx_q.pop_front();
        end
      end else begin
        m_rdata = st;
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
    end
    if (rx_push) rx_q.push_back(dev_in_data);
    if (flush) begin
      tx_q.delete();
      rx_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input bit r, input bit a, input logic [15:0] wd,
                            input int hold, input string tag);
    bus.cs = 1'b1;
    bus.rw = r;
    bus.addr = a;
    cpu_wdata = wd;
    cpu_oe = !r;
    tick(1'b1);
    chk({tag, "_ack"}, 32'(bus.ack), 32'(1));
    chk({tag, "_oe"}, 32'(dut.bus_oe), 32'(r));
    if (r) begin
      last_bus = bidir;
      chk({tag, "_data"}, 32'(bidir), 32'(m_rdata));
    end
    for (int i = 0; i < hold; i++) begin
      tick(1'b0);
      chk({tag, "_hold_ack"}, 32'(bus.ack), 32'(0));
      chk({tag, "_hold_oe"}, 32'(dut.bus_oe), 32'(r));
      if (r) chk({tag, "_hold_data"}, 32'(bidir), 32'(m_rdata));
    end
    bus.cs = 1'b0;
    cpu_oe = 1'b0;
    tick(1'b0);
    chk({tag, "_end_ack"}, 32'(bus.ack), 32'(0));
    chk({tag, "_end_oe"}, 32'(dut.bus_oe), 32'(0));
    tick(1'b0);
  endtask

  initial begin
    bus.cs = 1'b0;
    bus.rw = 1'b0;
    bus.addr = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("rst_ack", 32'(bus.ack), 32'(0));
    chk("rst_oe", 32'(dut.bus_oe), 32'(0));
    chk("rst_out_valid", 32'(dev_out_valid), 32'(0));
    chk("rst_out_data", 32'(dev_out_data), 32'(0));
    chk("rst_in_ready", 32'(dev_in_ready), 32'(1));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Two writes with the device stalled, then drain
    cpu_access(1'b0, 1'b0, 16'hA5A5, 0, "wr1");
    cpu_access(1'b0, 1'b0, 16'h1234, 0, "wr2");
    chk("tx_valid", 32'(dev_out_valid), 32'(1));
    chk("tx_head", 32'(dev_out_data), 32'(16'hA5A5));
    dev_out_ready = 1'b1;
    tick(1'b0);
    chk("tx_head2", 32'(dev_out_data), 32'(16'h1234));
    tick(1'b0);
    dev_out_ready = 1'b0;
    chk("tx_drained", 32'(dev_out_valid), 32'(0));

    // Device push then CPU data read
    dev_in_valid = 1'b1;
    dev_in_data = 16'hBEEF;
    tick(1'b0);
    dev_in_valid = 1'b0;
    cpu_access(1'b1, 1'b0, 16'h0, 1, "rd_beef");
    chk("rd_beef_val", 32'(last_bus), 32'(16'hBEEF));

    // Overflow: five writes into a DEPTH-4 FIFO
    cpu_access(1'b0, 1'b1, 16'h0003, 0, "ctl_flush");
    for (int i = 0; i < 5; i++) cpu_access(1'b0, 1'b0, 16'(16'h100 + i), 0, "ovf_wr");
    cpu_access(1'b1, 1'b1, 16'h0, 0, "stat1");
    chk("stat_ovf", 32'(last_bus), 32'(16'h4006));
    cpu_access(1'b1, 1'b1, 16'h0, 0, "stat2");
    chk("stat_ovf_clr", 32'(last_bus), 32'(16'h4002));

    // Underflow with a same-edge device push
    cpu_access(1'b0, 1'b1, 16'h0003, 0, "ctl_flush2");
    dev_in_valid = 1'b1;
    dev_in_data = 16'h0F0F;
    bus.cs = 1'b1;
    bus.rw = 1'b1;
    bus.addr = 1'b0;
    tick(1'b1);
    dev_in_valid = 1'b0;
    chk("unf_ack", 32'(bus.ack), 32'(1));
    chk("unf_data", 32'(bidir), 32'(16'h0000));
    bus.cs = 1'b0;
    tick(1'b0);
    tick(1'b0);
    cpu_access(1'b1, 1'b1, 16'h0, 0, "stat_unf");
    chk("stat_unf_val", 32'(last_bus), 32'(16'h0109));
    cpu_access(1'b1, 1'b0, 16'h0, 0, "rd_0f0f");
    chk("rd_0f0f_val", 32'(last_bus), 32'(16'h0F0F));

    // Long select: one pop, one ack
    dev_in_valid = 1'b1;
    dev_in_data = 16'h1111;
    tick(1'b0);
    dev_in_data = 16'h2222;
    tick(1'b0);
    dev_in_valid = 1'b0;
    cpu_access(1'b1, 1'b0, 16'h0, 5, "rd_long");
    chk("rd_long_val", 32'(last_bus), 32'(16'h1111));
    cpu_access(1'b1, 1'b1, 16'h0, 0, "stat_long");
    chk("stat_long_val", 32'(last_bus), 32'(16'h0101));

    // Randomized traffic against the model
    cpu_access(1'b0, 1'b1, 16'h0003, 0, "ctl_flush3");
    dev_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op < 4)      cpu_access(1'b0, 1'b0, 16'($urandom), int'($urandom_range(0, 2)), "rnd_wr");
      else if (op < 7) cpu_access(1'b1, 1'b0, 16'h0, int'($urandom_range(0, 2)), "rnd_rd");
      else if (op < 9) cpu_access(1'b1, 1'b1, 16'h0, int'($urandom_range(0, 2)), "rnd_stat");
      else             cpu_access(1'b0, 1'b1, 16'($urandom_range(0, 3)), 0, "rnd_ctl");
    end
    dev_rand = 1'b0;
    dev_in_valid = 1'b0;
    dev_out_ready = 1'b0;

    // Reset during the ACK cycle of a read
    cpu_access(1'b0, 1'b0, 16'h5555, 0, "pre_rst_wr");
    dev_in_valid = 1'b1;
    dev_in_data = 16'h7777;
    tick(1'b0);
    dev_in_valid = 1'b0;
    bus.cs = 1'b1;
    bus.rw = 1'b1;
    bus.addr = 1'b0;
    tick(1'b1);
    chk("ack_before_rst", 32'(bus.ack), 32'(1));
    chk("oe_before_rst", 32'(dut.bus_oe), 32'(1));
    reset = 1'b0;
    #1;
    chk("rst_mid_ack", 32'(bus.ack), 32'(0));
    chk("rst_mid_oe", 32'(dut.bus_oe), 32'(0));
    bus.cs = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    tick(1'b0);
    chk("post_rst_valid", 32'(dev_out_valid), 32'(0));
    chk("post_rst_ready", 32'(dev_in_ready), 32'(1));
    cpu_access(1'b1, 1'b1, 16'h0, 0, "stat_post_rst");
    chk("stat_post_rst_val", 32'(last_bus), 32'(16'h0000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
